// File: rtl/countdown_timer.sv
// Loadable down-counter with expiry pulse, sticky irq, and one-shot/auto-reload modes.
// Optional prescaler is built only when TIMER_PRESCALE_EN is defined.
module countdown_timer #(
  parameter int WIDTH     = 5,
  parameter int PSC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 enable,
  input  logic                 reload_en,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 irq_clr,
`ifdef TIMER_PRESCALE_EN
  input  logic [PSC_WIDTH-1:0] psc_div,
`endif
  output logic [WIDTH-1:0]     count_out,
  output logic                 expire,
  output logic                 irq,
  output logic                 busy,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  if (WIDTH < 2 || PSC_WIDTH < 1) begin : g_param_check
    $error("countdown_timer: WIDTH must be >= 2 and PSC_WIDTH >= 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;
  logic             irq_q, irq_d;
  logic             tick;

`ifdef TIMER_PRESCALE_EN
  logic [PSC_WIDTH-1:0] psc_q, psc_d;

  assign tick = enable && (psc_q == psc_div);

  // Prescaler runs on every enabled cycle regardless of FSM state; load realigns it.
  always_comb begin
    psc_d = psc_q;
    if (load) begin
      psc_d = '0;
    end else if (enable) begin
      psc_d = (psc_q == psc_div) ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign tick = enable;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;
    irq_d    = irq_q && !irq_clr;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - 1'b1;
            end else if (count_q == WIDTH'(1)) begin
              // Expiry wins over a simultaneous irq_clr.
              expire_d = 1'b1;
              irq_d    = 1'b1;
              if (reload_en) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_EXPIRED;
              end
            end
          end
        end
        S_IDLE, S_EXPIRED: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
      irq_q    <= irq_d;
    end
  end

  assign count_out   = count_q;
  assign expire      = expire_q;
  assign irq         = irq_q;
  assign busy        = (state_q == S_RUN);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios then random traffic,
// all outputs compared each cycle against a behavioural timer model.
module tb_countdown_timer;

  localparam int WIDTH = 5;
  localparam int PSC_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 load;
  logic                 enable;
  logic                 reload_en;
  logic [WIDTH-1:0]     load_val;
  logic                 irq_clr;
  logic [PSC_WIDTH-1:0] psc_div;
  logic [WIDTH-1:0]     count_out;
  logic                 expire;
  logic                 irq;
  logic                 busy;
  logic [1:0]           state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_count, m_reload, m_psc;
  bit m_running, m_expire, m_irq;

  countdown_timer #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .enable      (enable),
    .reload_en   (reload_en),
    .load_val    (load_val),
    .irq_clr     (irq_clr),
`ifdef TIMER_PRESCALE_EN
    .psc_div     (psc_div),
`endif
    .count_out   (count_out),
    .expire      (expire),
    .irq         (irq),
    .busy        (busy),
    .state_dbg_o (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_psc = 0;
    m_running = 0; m_expire = 0; m_irq = 0;
  endtask

  // One rising edge of the timer as described by its rules.
  task automatic model_edge();
    bit tk;
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef TIMER_PRESCALE_EN
    tk = enable && (m_psc == int'(psc_div));
`else
    tk = enable;
`endif
    m_expire = 0;
    if (irq_clr) m_irq = 0;
    if (load) begin
      m_count   = int'(load_val);
      m_reload  = int'(load_val);
      m_running = (load_val != 0);
      m_psc     = 0;
    end else begin
`ifdef TIMER_PRESCALE_EN
      if (enable) m_psc = (m_psc == int'(psc_div)) ? 0 : m_psc + 1;
`endif
      if (m_running && tk) begin
        if (m_count > 1) m_count = m_count - 1;
        else begin
          m_expire = 1;
          m_irq    = 1;
          if (reload_en) m_count = m_reload;
          else begin
            m_count   = 0;
            m_running = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count_out), 32'(m_count));
    check("expire", 32'(expire), 32'(m_expire));
    check("irq", 32'(irq), 32'(m_irq));
    check("busy", 32'(busy), 32'(m_running));
  endtask

  // Inputs are set by the caller after the previous check (1 time unit past the edge).
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit ld, input int val, input bit en, input bit rl, input bit clr);
    load = ld; load_val = WIDTH'(val); enable = en; reload_en = rl; irq_clr = clr;
  endtask

  initial begin
    rst = 1'b0;
    psc_div = '0;
    set_in(1, 5, 1, 0, 0);
    model_reset();
    #2;
    check_all();
    cycle(); cycle();

    // Release with load=5 held for one edge, then count down to expiry.
    rst = 1'b1;
    cycle();
    check("load5_count", 32'(count_out), 32'd5);
    set_in(0, 0, 1, 0, 0);
    repeat (5) cycle();
    check("oneshot_expire", 32'(expire), 32'd1);
    check("oneshot_count0", 32'(count_out), 32'd0);
    cycle();
    check("expire_one_cycle", 32'(expire), 32'd0);

    // Clear irq, then periodic mode with period 3.
    set_in(0, 0, 1, 0, 1); cycle();
    set_in(1, 3, 1, 1, 0); cycle();
    set_in(0, 0, 1, 1, 0);
    repeat (7) cycle();

    // Enable pattern 1,0,0,1 from count 4.
    set_in(1, 4, 1, 0, 0); cycle();
    set_in(0, 0, 1, 0, 0); cycle();
    enable = 0; cycle(); cycle();
    enable = 1; cycle();
    check("enable_hold_count", 32'(count_out), 32'd2);
    repeat (3) cycle();

    // Load on the expiry tick: load wins.
    set_in(1, 2, 1, 0, 1); cycle();
    set_in(0, 0, 1, 0, 0); cycle();
    set_in(1, 7, 1, 0, 0); cycle();
    check("load_beats_expire", 32'(expire), 32'd0);
    check("load_beats_count", 32'(count_out), 32'd7);

    // irq_clr coinciding with an expiry keeps irq set.
    set_in(1, 1, 1, 0, 0); cycle();
    set_in(0, 0, 1, 0, 1); cycle();
    check("clr_vs_set_irq", 32'(irq), 32'd1);
    set_in(0, 0, 1, 0, 0); cycle();

    // Load zero goes idle.
    set_in(1, 0, 1, 1, 0); cycle();
    set_in(0, 0, 1, 1, 0); cycle(); cycle();

    // Asynchronous reset mid-count.
    set_in(1, 6, 1, 0, 0); cycle();
    set_in(0, 0, 1, 0, 0); cycle(); cycle();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b1;
    cycle();

`ifdef TIMER_PRESCALE_EN
    psc_div = 4'd2;
    set_in(1, 2, 1, 0, 0); cycle();
    set_in(0, 0, 1, 0, 0);
    repeat (6) cycle();
    check("psc_expire", 32'(expire), 32'd1);
    repeat (2) cycle();
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 15) == 0), $urandom_range(0, 31) % ($urandom_range(0, 3) == 0 ? 4 : 32),
             ($urandom_range(0, 9) != 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
`ifdef TIMER_PRESCALE_EN
      if ($urandom_range(0, 63) == 0) psc_div = PSC_WIDTH'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
      end else begin
        rst = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
